// File: rtl/tick_delay_arbiter_pkg.sv
// tick_delay_arbiter_pkg: shared FSM state encoding and width helper
package tick_delay_arbiter_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  function automatic int clog2(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return w;
  endfunction
endpackage

// File: rtl/tick_delay_arbiter_tick_prescaler.sv
// tick_delay_arbiter_tick_prescaler: mod-(m+1) counter emitting a tick on its terminal count
module tick_delay_arbiter_tick_prescaler
  import tick_delay_arbiter_pkg::*;
#(
  parameter int M_BITS = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic [M_BITS-1:0] mod_i,
  output logic              tick_o
);
  logic [M_BITS-1:0] cnt_q, cnt_d;
  // Tick on terminal count; clear wins, otherwise wrap back to zero after the tick
  always_comb begin
    tick_o = en_i && (cnt_q == mod_i);
    cnt_d = clr_i ? '0 : !en_i ? cnt_q : tick_o ? '0 : cnt_q + 1'b1;
  end
  // Count register
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/tick_delay_arbiter.sv
// tick_delay_arbiter: round-robin sharing of one prescaled delay timer among requesters
module tick_delay_arbiter
  import tick_delay_arbiter_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int M_BITS = 8,
  parameter int D_BITS = 8,
  localparam int ID_W  = clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [M_BITS-1:0]       m,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*D_BITS-1:0] delay,
  output logic [N_REQ-1:0]        gnt,
  output logic [N_REQ-1:0]        done,
  output logic                    busy,
  output logic [ID_W-1:0]         active_id
);
  state_t            state_q;
  logic [N_REQ-1:0]  gnt_q, done_q;
  logic              busy_q;
  logic [ID_W-1:0]   id_q, rr_q, sel, rr_nxt;
  logic [D_BITS-1:0] rem_q;
  logic [M_BITS-1:0] m_q;
  logic              tick;

  function automatic logic [ID_W-1:0] rr_pick(input logic [N_REQ-1:0] r, input logic [ID_W-1:0] p);
    logic [ID_W-1:0] s;
    logic f;
    s = '0;
    f = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      int k;
      k = (int'(p) + i) % N_REQ;
      if (!f && r[k]) begin
        s = ID_W'(k);
        f = 1'b1;
      end
    end
    return s;
  endfunction

  tick_delay_arbiter_tick_prescaler #(.M_BITS(M_BITS)) u_pre (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (state_q != RUN),
    .en_i   (state_q == RUN),
    .mod_i  (m_q),
    .tick_o (tick)
  );

  // Round-robin winner and the pointer value that follows it
  always_comb begin
    sel = rr_pick(req, rr_q);
    rr_nxt = (sel == ID_W'(N_REQ - 1)) ? '0 : sel + 1'b1;
  end

  // Grant, countdown, abort and completion with registered handshake outputs
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      id_q    <= '0;
      rr_q    <= '0;
      rem_q   <= '0;
      m_q     <= '0;
    end else begin
      done_q <= '0;
      case (state_q)
        IDLE: if (|req) begin
          state_q <= RUN;
          gnt_q   <= N_REQ'(1) << sel;
          id_q    <= sel;
          busy_q  <= 1'b1;
          m_q     <= m;
          rem_q   <= delay[sel*D_BITS +: D_BITS];
          rr_q    <= rr_nxt;
        end
        RUN: if (!req[id_q]) begin
          state_q <= IDLE;
          gnt_q   <= '0;
          busy_q  <= 1'b0;
        end else if (rem_q == '0 || (tick && rem_q == D_BITS'(1))) begin
          state_q <= DONE;
          gnt_q   <= '0;
          done_q  <= N_REQ'(1) << id_q;
        end else if (tick) begin
          rem_q <= rem_q - 1'b1;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end

  assign gnt       = gnt_q;
  assign done      = done_q;
  assign busy      = busy_q;
  assign active_id = id_q;
endmodule

// File: doc/tick_delay_arbiter.md
Name: tick_delay_arbiter

Overview:
- Shares one programmable tick prescaler and delay down-counter among N_REQ requesters. Each requester gets a timed delay of D prescaler ticks.
- Requesters use a req/gnt/done handshake. Only one delay runs at a time, and requesters are served in round-robin order.
- Sits between control FSMs (display refresh, sensor poll, debounce) and the timebase, so each client does not need its own divider.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- M_BITS, 8, width of prescale modulus m
- D_BITS, 8, width of per-requester delay count

Ports:
- clk  in  1  system clock
- reset  in  1  reset, asynchronous, active-high
- m  in  M_BITS  prescale modulus; tick period is m+1 clocks; sampled at grant
- req  in  N_REQ  per-requester request level; held high until done
- delay  in  N_REQ*D_BITS  packed delays; requester i occupies bits [i*D_BITS +: D_BITS]; sampled at grant
- gnt  out  N_REQ  one-hot grant, high while that requester's delay runs
- done  out  N_REQ  one-hot, one-cycle completion pulse
- busy  out  1  high in RUN and DONE
- active_id  out  clog2(N_REQ)  index of the current or most recent grantee

Behaviour:
- Reset (async): state=IDLE, gnt=0, done=0, busy=0, active_id=0, rr pointer=0, prescaler count=0, remaining=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - If req!=0, select the first set bit scanning from the rr pointer upward, with wrap.
  - Next cycle: state=RUN, gnt[sel]=1, active_id=sel.
  - Latch m_lat=m and remaining=delay[sel]. Clear the prescaler count. Set the rr pointer to (sel+1) mod N_REQ.
- RUN:
  - Prescaler count increments each clock, 0..m_lat, then wraps to 0.
  - tick is combinational, high when count==m_lat; m_lat=0 gives a tick every clock.
  - On a tick with remaining>1: remaining decrements.
  - On a tick with remaining==1, or on any RUN cycle with remaining==0: go to DONE next cycle.
- DONE (one cycle): done[active_id]=1, gnt=0, busy=1. Next state is IDLE unconditionally.
- Latency: with req sampled in IDLE at cycle 0, done is high at cycle 1+D*(m+1) for D>=1, and at cycle 2 for D=0.
- Minimum gap: one IDLE cycle between a done pulse and the next gnt, including back-to-back requests.
- Abort:
  - If req[active_id] falls during RUN, go to IDLE next cycle with gnt=0 and no done pulse.
  - Abort takes priority over completion in the same cycle.
- Simultaneous requests are resolved only by round robin; the other requesters stay pending.
- Changing m or delay during RUN has no effect until the next grant.
- Reset asserted mid-RUN: all outputs clear immediately, no done pulse.
- req bits rising while busy are ignored until IDLE.
- Arithmetic: remaining and count are unsigned. Never underflow; hold at 0.

Decomposition:
- Shared package holds:
  - the state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - a clog2 helper function for the active_id width.
- Sub-module tick_prescaler: counter with clear, enable and modulus inputs, and a tick output. Reusable elsewhere as the timebase.
- The round-robin selector stays inline as a combinational function.

Test Plan:
1. N_REQ=4, m=0, req=0001, delay0=3: gnt[0] high cycles 1-3; done[0] high at cycle 4; busy low at cycle 5.
2. m=2, req=0100, delay2=2: done[2] at cycle 7; tick high at cycles 3 and 6 only.
3. req=1111 held, all delays=1, m=0: grants go in order 0,1,2,3,0; each done is followed by one IDLE cycle; the rr pointer wraps.
4. delay1=0, req=0010: gnt[1] high at cycle 1 only; done[1] at cycle 2.
5. req=0001, delay0=10, m=1, drop req[0] at cycle 5: gnt=0 at cycle 6, no done pulse, next pending requester granted at cycle 7.
6. Assert reset at cycle 4 of a delay0=8 run: gnt, done, busy and active_id are 0 in the same cycle. After release, req=0001 grants requester 0 with a fresh count.
